ms_display_driver: RTL and testbench

//   Downstream consumer of the 14-bit millisecond PIO output. Converts the binary value to
//   4 BCD digits with a sequential double-dabble engine and drives four static 7-segment

---
 rtl/ms_display_pkg.sv | 26 ++
 rtl/ms_display_driver_seg7_encoder.sv | 25 ++
 rtl/ms_display_driver.sv | 163 ++++++++++++++++
 tb/tb_ms_display_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ms_display_pkg.sv
// +--------------------------------------------------------------------------+
// | ms_display_pkg : shared types and segment constants for ms_display_driver |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package ms_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Segment vectors are {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

`default_nettype wire

// File: rtl/ms_display_driver_seg7_encoder.sv
// +--------------------------------------------------------------------------+
// | seg7_encoder : BCD nibble to active-high 7-segment pattern, with blanking |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_encoder
    import ms_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        // Non-decimal nibbles stay dark.
        if (!blank && (nibble < 4'd10)) begin
            seg = SEG_TABLE[nibble];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ms_display_driver.sv
// +--------------------------------------------------------------------------+
// | ms_display_driver : binary ms value -> 4-digit BCD -> four 7-seg displays |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module ms_display_driver
    import ms_display_pkg::*;
#(
    parameter int WIDTH         = 14,
    parameter int DIGITS        = 4,
    parameter int MAX_VALUE     = 9999,
    parameter int BLANK_LEADING = 1,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam int               BCD_W    = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VALUE);
    localparam logic             POL      = (ACTIVE_LOW != 0);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   last_val;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               pending;
    logic               start;
    logic               do_shift;
    logic               do_load;
    logic [DIGITS-1:0]  blank;
    logic               hi_zero;
    logic [6:0]         seg_enc [DIGITS];
    logic [6:0]         seg_q   [DIGITS];
    logic [6:0]         seg_out [DIGITS];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        do_shift   = 1'b0;
        do_load    = 1'b0;
        case (state)
            IDLE: begin
                if (pending || (data_in != last_val)) begin
                    start      = 1'b1;
                    next_state = CONV;
                end
            end
            CONV: begin
                do_shift = 1'b1;
                if (cnt == CNT_LAST) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                do_load    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == CONV) || (state == LOAD);

    // ------------------------------------------------------------------
    // Double-dabble datapath: per-nibble +3 correction, no carry between
    // nibbles, then {bcd, shift_reg} shifts left one bit.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3)
                                                           : bcd[4*i +: 4];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            last_val  <= '0;
            bcd       <= '0;
            cnt       <= '0;
            pending   <= 1'b1;
        end else if (start) begin
            shift_reg <= data_in;
            last_val  <= data_in;
            bcd       <= '0;
            cnt       <= '0;
            pending   <= 1'b0;
        end else if (do_shift) begin
            bcd       <= {bcd_adj[BCD_W-2:0], shift_reg[WIDTH-1]};
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            cnt       <= cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking and segment encoding
    // ------------------------------------------------------------------
    always_comb begin
        hi_zero = 1'b1;
        blank   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero  = hi_zero & (bcd[4*i +: 4] == 4'd0);
            blank[i] = (BLANK_LEADING != 0) && (i > 0) && hi_zero;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_enc
        seg7_encoder u_enc (
            .nibble (bcd[4*i +: 4]),
            .blank  (blank[i]),
            .seg    (seg_enc[i])
        );
    end

    // Output registers only change in LOAD so the displays never show a
    // partially converted value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                seg_q[i] <= SEG_BLANK;
            end
        end else if (do_load) begin
            for (int i = 0; i < DIGITS; i++) begin
                seg_q[i] <= (last_val > MAX_V) ? SEG_DASH : seg_enc[i];
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_out
        assign seg_out[i] = enable ? (seg_q[i] ^ {7{POL}}) : {7{POL}};
    end

    assign hex0 = seg_out[0];
    assign hex1 = seg_out[1];
    assign hex2 = seg_out[2];
    assign hex3 = seg_out[3];

endmodule

`default_nettype wire

// File: tb/tb_ms_display_driver.sv
// +--------------------------------------------------------------------------+
// | tb_ms_display_driver : self-checking bench for ms_display_driver          |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ms_display_driver;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b1;
    logic [13:0] data_in = 14'd0;
    logic [6:0]  ha [4];
    logic [6:0]  hb [4];
    logic        busy_a;
    logic        busy_b;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    ms_display_driver u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .data_in (data_in),
        .enable  (enable),
        .hex0    (ha[0]),
        .hex1    (ha[1]),
        .hex2    (ha[2]),
        .hex3    (ha[3]),
        .busy    (busy_a)
    );

    ms_display_driver #(.BLANK_LEADING(0)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .data_in (data_in),
        .enable  (enable),
        .hex0    (hb[0]),
        .hex1    (hb[1]),
        .hex2    (hb[2]),
        .hex3    (hb[3]),
        .busy    (busy_b)
    );

    // Behavioural model: a conversion takes 15 clocks from the latch edge,
    // then the latched value is shown in decimal.
    int m_cnt;
    bit m_pending;
    int m_last;
    int m_val;
    bit m_shown;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt     = 0;
            m_pending = 1'b1;
            m_last    = 0;
            m_val     = 0;
            m_shown   = 1'b0;
        end else if (m_cnt == 0) begin
            if (m_pending || (int'(data_in) != m_last)) begin
                m_last    = int'(data_in);
                m_pending = 1'b0;
                m_cnt     = 15;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_shown = 1'b1;
                m_val   = m_last;
            end
        end
    end

    function automatic logic [6:0] digit_al(int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    function automatic logic [6:0] exp_hex(int v, bit shown, int i, bit bl, bit en);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (!en || !shown) return 7'h7F;
        if (v > 9999) return 7'h3F;
        if (bl && (i > 0) && (v < p)) return 7'h7F;
        return digit_al((v / p) % 10);
    endfunction

    task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cyc_a_hex%0d", i), ha[i], exp_hex(m_val, m_shown, i, 1'b1, enable));
                chk($sformatf("cyc_b_hex%0d", i), hb[i], exp_hex(m_val, m_shown, i, 1'b0, enable));
            end
            chk("cyc_busy_a", {6'd0, busy_a}, {6'd0, m_cnt != 0});
            chk("cyc_busy_b", {6'd0, busy_b}, {6'd0, m_cnt != 0});
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(3);
        cmp_on = 1'b1;
        chk("rst_hex0", ha[0], 7'h7F);
        chk("rst_busy", {6'd0, busy_a}, 7'd0);

        // Test 1: first conversion after reset release
        reset_n = 1'b1;
        tick(1);
        chk("t1_busy_edge1", {6'd0, busy_a}, 7'd1);
        tick(14);
        chk("t1_busy_edge15", {6'd0, busy_a}, 7'd1);
        chk("t1_hex0_edge15", ha[0], 7'h7F);
        tick(1);
        chk("t1_hex0", ha[0], 7'h40);
        chk("t1_hex1", ha[1], 7'h7F);
        chk("t1_hex3", ha[3], 7'h7F);
        chk("t1_busy_done", {6'd0, busy_a}, 7'd0);

        // Test 2: 1234
        data_in = 14'd1234;
        tick(16);
        chk("t2_hex3", ha[3], 7'h79);
        chk("t2_hex2", ha[2], 7'h24);
        chk("t2_hex1", ha[1], 7'h30);
        chk("t2_hex0", ha[0], 7'h19);

        // Test 3: limit and overflow
        data_in = 14'd9999;
        tick(16);
        chk("t3_9999_hex3", ha[3], 7'h10);
        chk("t3_9999_hex0", ha[0], 7'h10);
        data_in = 14'd10000;
        tick(16);
        chk("t3_10000_hex3", ha[3], 7'h3F);
        chk("t3_10000_hex0", ha[0], 7'h3F);
        data_in = 14'd16383;
        tick(16);
        chk("t3_16383_hex2", ha[2], 7'h3F);
        chk("t3_16383_b_hex1", hb[1], 7'h3F);

        // Test 4: change on the third CONV cycle
        data_in = 14'd100;
        tick(3);
        data_in = 14'd205;
        tick(13);
        chk("t4_100_hex0", ha[0], 7'h40);
        chk("t4_100_hex1", ha[1], 7'h40);
        chk("t4_100_hex2", ha[2], 7'h79);
        chk("t4_100_hex3", ha[3], 7'h7F);
        tick(16);
        chk("t4_205_hex0", ha[0], 7'h12);
        chk("t4_205_hex1", ha[1], 7'h40);
        chk("t4_205_hex2", ha[2], 7'h24);

        // Test 5: no leading blanking, then enable gating
        data_in = 14'd7;
        tick(16);
        chk("t5_b_hex3", hb[3], 7'h40);
        chk("t5_b_hex1", hb[1], 7'h40);
        chk("t5_b_hex0", hb[0], 7'h78);
        chk("t5_a_hex1", ha[1], 7'h7F);
        enable = 1'b0;
        #1;
        chk("t5_dis_a_hex0", ha[0], 7'h7F);
        chk("t5_dis_b_hex3", hb[3], 7'h7F);
        tick(3);
        enable = 1'b1;
        #1;
        chk("t5_en_a_hex0", ha[0], 7'h78);
        chk("t5_en_b_hex2", hb[2], 7'h40);

        // Test 6: reset during CONV
        data_in = 14'd4321;
        tick(5);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_hex0", ha[0], 7'h7F);
        chk("t6_rst_busy", {6'd0, busy_a}, 7'd0);
        tick(2);
        reset_n = 1'b1;
        tick(15);
        chk("t6_hex0_edge15", ha[0], 7'h7F);
        tick(1);
        chk("t6_hex0", ha[0], 7'h79);
        chk("t6_hex1", ha[1], 7'h24);
        chk("t6_hex2", ha[2], 7'h30);
        chk("t6_hex3", ha[3], 7'h19);
        tick(4);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
